// File: rtl/chip_if_pkg.sv
// rtl/chip_if_pkg.sv - shared widths, state encoding and bank sizing for the chip link receiver
package chip_if_pkg;

  localparam int ADDR_W_DEF     = 3;
  localparam int DATA_W_DEF     = 8;
  localparam int FRAME_BITS_DEF = ADDR_W_DEF + DATA_W_DEF;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

  function automatic int bank_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchroniser with optional rising-edge detect
module sync_edge_det #(
  parameter bit HAS_RISE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign sync = s2;

  generate
    if (HAS_RISE) begin : g_rise
      logic s3;
      always_ff @(posedge clk) begin
        if (rst) s3 <= 1'b0;
        else     s3 <= s2;
      end
      assign rise = s2 & ~s3;
    end else begin : g_no_rise
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/chip_serial_rx.sv
// rtl/chip_serial_rx.sv - oversampling receiver for {address, level} frames on the chip config link
module chip_serial_rx
  import chip_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_rst,
  input  logic              chip_clk,
  input  logic              chip_data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_level,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_level,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int FRAME_BITS = ADDR_W + DATA_W;
  localparam int DEPTH      = bank_depth(ADDR_W);
  localparam int BCW        = $clog2(FRAME_BITS + 1);
  localparam int ICW        = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_BITS - 1);
  localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT - 1);

  logic link_rise;
  logic link_data;
  logic link_rst;
  logic clk_sync_unused;
  logic data_rise_unused;
  logic rst_rise_unused;

  sync_edge_det #(.HAS_RISE(1'b1)) u_sync_clk (
    .clk (clk), .rst (rst), .din (chip_clk), .sync (clk_sync_unused), .rise (link_rise)
  );
  sync_edge_det #(.HAS_RISE(1'b0)) u_sync_data (
    .clk (clk), .rst (rst), .din (chip_data_in), .sync (link_data), .rise (data_rise_unused)
  );
  sync_edge_det #(.HAS_RISE(1'b0)) u_sync_rst (
    .clk (clk), .rst (rst), .din (chip_rst), .sync (link_rst), .rise (rst_rise_unused)
  );

  rx_state_t             state, state_next;
  logic [FRAME_BITS-1:0] shift, shift_next;
  logic [BCW-1:0]        bit_cnt, bit_cnt_next;
  logic [ICW-1:0]        idle_cnt, idle_next;
  logic                  commit;
  logic                  err_inc;
  logic [DATA_W-1:0]     bank [DEPTH];

  wire [ADDR_W-1:0] frame_addr  = shift_next[FRAME_BITS-1:DATA_W];
  wire [DATA_W-1:0] frame_level = shift_next[DATA_W-1:0];

  // Link reset overrides everything; a frame in flight when it arrives is an error,
  // including one whose final bit lands in the same cycle.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    idle_next    = '0;
    commit       = 1'b0;
    err_inc      = 1'b0;
    if (link_rst) begin
      state_next   = HOLD;
      shift_next   = '0;
      bit_cnt_next = '0;
      err_inc      = (state == SHIFT);
    end else begin
      case (state)
        HOLD: state_next = IDLE;
        IDLE: begin
          if (link_rise) begin
            shift_next   = {{(FRAME_BITS-1){1'b0}}, link_data};
            bit_cnt_next = BCW'(1);
            state_next   = SHIFT;
          end
        end
        SHIFT: begin
          if (idle_cnt == IDLE_LIMIT) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_cnt_next = '0;
            err_inc      = 1'b1;
          end else if (link_rise) begin
            shift_next   = {shift[FRAME_BITS-2:0], link_data};
            bit_cnt_next = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              commit       = 1'b1;
              bit_cnt_next = '0;
              state_next   = IDLE;
            end
          end else begin
            idle_next = idle_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      rx_valid    <= 1'b0;
      rx_addr     <= '0;
      rx_level    <= '0;
      rd_level    <= '0;
      frame_count <= '0;
      err_count   <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      idle_cnt <= idle_next;
      rx_valid <= commit;
      rd_level <= bank[rd_addr];
      if (commit) begin
        rx_addr          <= frame_addr;
        rx_level         <= frame_level;
        bank[frame_addr] <= frame_level;
        if (frame_count != '1) frame_count <= frame_count + 1'b1;
      end
      if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_chip_serial_rx.sv
// tb/tb_chip_serial_rx.sv - self-checking bench for chip_serial_rx
module tb_chip_serial_rx;

  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chip_rst = 1'b0;
  logic       chip_clk = 1'b0;
  logic       chip_data_in = 1'b0;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_level;
  logic       rx_valid;
  logic [2:0] rx_addr;
  logic [7:0] rx_level;
  logic       busy;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  chip_serial_rx #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .chip_rst (chip_rst), .chip_clk (chip_clk),
    .chip_data_in (chip_data_in), .rd_addr (rd_addr), .rd_level (rd_level),
    .rx_valid (rx_valid), .rx_addr (rx_addr), .rx_level (rx_level), .busy (busy),
    .frame_count (frame_count), .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model of what the chip should have received
  logic [7:0]  m_bank [8];
  int          m_fc = 0;
  int          m_ec = 0;
  int          m_pulses = 0;
  logic [10:0] exp_q [$];

  // Monitor
  logic [10:0] got_q [$];
  int          pulses = 0;
  int          wide = 0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back({rx_addr, rx_level});
      pulses++;
      if (prev_v) wide++;
    end
    prev_v = rx_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input int half);
    chip_data_in = b;
    tick(half);
    chip_clk = 1'b1;
    tick(half);
    chip_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [7:0] l, input int half);
    logic [10:0] w;
    w = {a, l};
    for (int i = 10; i >= 0; i--) send_bit(w[i], half);
  endtask

  task automatic send_partial(input int n, input int half);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), half);
  endtask

  task automatic model_frame(input logic [2:0] a, input logic [7:0] l);
    m_bank[a] = l;
    if (m_fc < 65535) m_fc++;
    m_pulses++;
    exp_q.push_back({a, l});
  endtask

  task automatic model_err();
    if (m_ec < 65535) m_ec++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_fc = 0;
    m_ec = 0;
  endtask

  task automatic read_bank(input int a, output int v);
    rd_addr = 3'(a);
    tick(1);
    v = int'(rd_level);
  endtask

  task automatic link_rst_pulse(input int n);
    chip_rst = 1'b1;
    tick(n);
    chip_rst = 1'b0;
    tick(5);
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({name, "_frame"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] level;
    bit         b2b;
    logic [2:0] exp_addr;
    logic [7:0] exp_level;
    int         exp_fc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int v;
    vecs[0] = '{3'd1, 8'h05, 1'b0, 3'd1, 8'h05, 1};
    vecs[1] = '{3'd2, 8'h08, 1'b0, 3'd2, 8'h08, 2};
    vecs[2] = '{3'd2, 8'h07, 1'b1, 3'd2, 8'h07, 3};
    vecs[3] = '{3'd7, 8'hFF, 1'b0, 3'd7, 8'hFF, 4};
    vecs[4] = '{3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 5};
    vecs[5] = '{3'd5, 8'h5A, 1'b0, 3'd5, 8'h5A, 6};
    model_reset();

    tick(3);
    rst = 1'b0;
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_level", int'(rd_level), 0);
    tick(4);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) tick(6);
      send_frame(vecs[i].addr, vecs[i].level, 10);
      model_frame(vecs[i].addr, vecs[i].level);
      chk("vec_rx_addr", int'(rx_addr), int'(vecs[i].exp_addr));
      chk("vec_rx_level", int'(rx_level), int'(vecs[i].exp_level));
      chk("vec_frame_count", int'(frame_count), vecs[i].exp_fc);
      chk("vec_err_count", int'(err_count), 0);
      chk("vec_pulses", pulses, m_pulses);
    end
    tick(6);
    read_bank(1, v); chk("bank1", v, 5);
    read_bank(2, v); chk("bank2", v, 7);
    read_bank(7, v); chk("bank7", v, 255);
    read_bank(5, v); chk("bank5", v, 'h5A);
    read_bank(3, v); chk("bank3_untouched", v, 0);
    compare_queues("table");

    // Partial frame aborted by link reset
    send_partial(5, 10);
    tick(2);
    chk("partial_busy", int'(busy), 1);
    link_rst_pulse(10);
    model_err();
    chk("partial_err_count", int'(err_count), 1);
    chk("partial_no_pulse", pulses, m_pulses);
    chk("partial_busy_after", int'(busy), 0);
    send_frame(3'd3, 8'hA5, 10);
    model_frame(3'd3, 8'hA5);
    chk("after_rst_rx_addr", int'(rx_addr), 3);
    chk("after_rst_rx_level", int'(rx_level), 'hA5);
    chk("after_rst_frame_count", int'(frame_count), 7);

    // Timeout mid-frame
    tick(6);
    send_partial(6, 10);
    chk("timeout_busy_before", int'(busy), 1);
    tick(TIMEOUT + 10);
    model_err();
    chk("timeout_err_count", int'(err_count), 2);
    chk("timeout_busy_after", int'(busy), 0);
    send_frame(3'd4, 8'h3C, 10);
    model_frame(3'd4, 8'h3C);
    chk("after_timeout_rx_addr", int'(rx_addr), 4);
    chk("after_timeout_rx_level", int'(rx_level), 'h3C);

    // Full burst while link reset held
    tick(6);
    chip_rst = 1'b1;
    tick(5);
    send_frame(3'd6, 8'h11, 10);
    tick(3);
    chip_rst = 1'b0;
    tick(5);
    chk("held_rst_pulses", pulses, m_pulses);
    chk("held_rst_frame_count", int'(frame_count), m_fc);
    chk("held_rst_err_count", int'(err_count), m_ec);
    chk("held_rst_rx_addr", int'(rx_addr), 4);
    compare_queues("directed");

    // System reset mid-frame
    send_partial(4, 10);
    rst = 1'b1;
    tick(1);
    chk("midrst_rx_valid", int'(rx_valid), 0);
    chk("midrst_rx_addr", int'(rx_addr), 0);
    chk("midrst_rx_level", int'(rx_level), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_count", int'(frame_count), 0);
    chk("midrst_err_count", int'(err_count), 0);
    chk("midrst_rd_level", int'(rd_level), 0);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    tick(4);
    read_bank(3, v); chk("midrst_bank3", v, 0);
    read_bank(1, v); chk("midrst_bank1", v, 0);
    send_frame(3'd6, 8'h99, 10);
    model_frame(3'd6, 8'h99);
    chk("post_rst_rx_addr", int'(rx_addr), 6);
    chk("post_rst_rx_level", int'(rx_level), 'h99);
    chk("post_rst_frame_count", int'(frame_count), 1);

    // Randomised traffic against the model
    for (int n = 0; n < 40; n++) begin
      int half;
      half = int'($urandom_range(4, 8));
      if ($urandom_range(0, 4) == 0) begin
        send_partial(int'($urandom_range(1, 10)), half);
        link_rst_pulse(8);
        model_err();
      end else begin
        logic [2:0] a;
        logic [7:0] l;
        a = 3'($urandom);
        l = 8'($urandom);
        send_frame(a, l, half);
        model_frame(a, l);
        if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(1, 20)));
      end
    end
    tick(10);
    compare_queues("random");
    chk("random_frame_count", int'(frame_count), m_fc);
    chk("random_err_count", int'(err_count), m_ec);
    chk("random_pulses", pulses, m_pulses);
    for (int i = 0; i < 8; i++) begin
      read_bank(i, v);
      chk("random_bank", v, int'(m_bank[i]));
    end
    chk("rx_valid_pulse_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
